multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16, giving the maximum cycles to wait for mem_ready_i; 0 disables the timeout.
REQ-002 The block SHALL have parameter TIMEOUT_W, default 5, giving the wait-counter width; it SHALL hold MEM_TIMEOUT.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The ports SHALL be, in order:
  clk_i  in  1  clock, rising edge
  rst_i  in  1  reset
  op_i  in  7  instr[6:0] from the instruction register
  funct3_i  in  3  instr[14:12]
  funct7bit_i  in  1  instr[30]
  branch_taken_i  in  1  branch compare result from the datapath
  mem_ready_i  in  1  memory completion strobe
  pc_en_o  out  1  PC write enable
  ir_en_o  out  1  instruction-register load
  regWrite_en_o  out  1  register-file write
  ALUctrl_o  out  4  ALU operation
  ALUsrcA_o  out  1  0=rs1, 1=PC
  ALUsrcB_o  out  1  0=rs2, 1=immediate
  immSrc_o  out  3  extend type: 000 I, 001 S, 010 B, 011 U, 100 J
  resultSrc_o  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4
  PCsrc_o  out  2  next PC: 00 PC+4, 01 PC+imm, 10 ALU result
  mem_req_o  out  1  memory request
  mem_we_o  out  1  memory write
  mem_size_o  out  3  funct3 passed through on loads and stores
  instr_done_o  out  1  retire pulse
  trap_o  out  1  sticky trap flag
  trap_cause_o  out  2  01 illegal opcode, 10 memory timeout

Function
REQ-005 The states SHALL be FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and TRAP.
REQ-006 In FETCH the block SHALL drive mem_req_o=1 and mem_we_o=0, and SHALL stay in FETCH until mem_ready_i=1; in the ready cycle it SHALL pulse ir_en_o and go to DECODE.
REQ-007 In DECODE the block SHALL latch op/funct3/funct7bit internally.
REQ-008 From DECODE, an opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111} SHALL go to TRAP with cause 01; any listed opcode SHALL go to EXECUTE.
REQ-009 ALUctrl_o SHALL use: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, srl 0111, sll 1000, sra 1001.
REQ-010 For R-type, funct3 000 with bit30=1 SHALL decode as sub.
REQ-011 For I-type ALU (0010011), funct3 000 SHALL always decode as add, ignoring bit30.
REQ-012 For both R-type and I-type ALU, funct3 101 with bit30 SHALL select sra, and without bit30 SHALL select srl.
REQ-013 Branches SHALL use sub for beq/bne, slt for blt/bge and sltu for bltu/bgeu.
REQ-014 Loads, stores, jalr, lui and auipc SHALL use add.
REQ-015 EXECUTE for R-type, I-ALU, lui and auipc SHALL go to WRITEBACK.
REQ-016 EXECUTE for loads and stores SHALL go to MEMORY.
REQ-017 EXECUTE for a branch SHALL go to FETCH with pc_en_o=1 and instr_done_o=1; PCsrc_o SHALL be 01 if branch_taken_i else 00.
REQ-018 EXECUTE for jal/jalr SHALL go to WRITEBACK.
REQ-019 In MEMORY the block SHALL drive mem_req_o=1 and mem_we_o=1 for stores only, and SHALL wait for mem_ready_i.
REQ-020 On mem_ready_i in MEMORY, a store SHALL return to FETCH with pc_en_o=1, PCsrc_o=00 and instr_done_o=1; a load SHALL go to WRITEBACK.
REQ-021 WRITEBACK SHALL assert regWrite_en_o, pc_en_o and instr_done_o for one cycle, then go to FETCH.
REQ-022 In WRITEBACK, resultSrc_o SHALL be 01 for loads and 10 for jal/jalr, else 00.
REQ-023 In WRITEBACK, PCsrc_o SHALL be 01 for jal, 10 for jalr, else 00.
REQ-024 A wait counter SHALL clear on entry to FETCH and to MEMORY, and SHALL increment each cycle mem_ready_i=0 in those states.
REQ-025 When the wait counter reaches MEM_TIMEOUT (MEM_TIMEOUT≠0), the block SHALL go to TRAP with cause 10; mem_ready_i arriving in that same cycle SHALL win and complete normally.
REQ-026 TRAP SHALL be absorbing: trap_o=1, every enable and request 0, and trap_cause_o held until reset.
REQ-027 ALUctrl_o, immSrc_o and mem_size_o SHALL be derived from the latched fields from DECODE onward; all enables SHALL be zero in states not listed above.
REQ-028 In FETCH the block SHALL drive ALUctrl_o=0000.

Reset
REQ-029 While rst_i=1, all outputs SHALL be 0.
REQ-030 On release of rst_i, the state SHALL be FETCH, the wait counter 0, and trap_o/trap_cause_o cleared.
REQ-031 Reset asserted in any state, including MEMORY mid-wait or TRAP, SHALL take effect at the next edge, with no memory write issued in that cycle.

Verification
REQ-032 sub x3,x1,x2 (op 0110011, f3 000, b30=1), ready in first fetch cycle -> ALUctrl_o=0001, regWrite_en_o pulse 3 cycles after ready, instr_done_o once.
REQ-033 addi with b30=1 -> ALUctrl_o=0000; srai (f3 101, b30=1) -> 1001.
REQ-034 lw with mem_ready_i delayed 3 cycles in MEMORY -> mem_req_o high 4 cycles, then resultSrc_o=01 with regWrite_en_o in WRITEBACK.
REQ-035 beq with branch_taken_i=1 -> PCsrc_o=01 and pc_en_o in EXECUTE, regWrite_en_o never asserted.
REQ-036 op 1111111 -> trap_o=1, trap_cause_o=01, mem_req_o=0 thereafter; MEM_TIMEOUT=4 with mem_ready_i held 0 in FETCH -> trap_cause_o=10 after 4 cycles.
REQ-037 rst_i pulsed during a store's MEMORY wait -> mem_we_o=0 next cycle, FETCH entered, no instr_done_o.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32I control FSM with memory wait timeout and sticky trap
//
// Sequences FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] and drives the
// datapath enables, ALU/immediate/result/PC selects and the memory handshake.
// Ports:
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   op_i, funct3_i,
//   funct7bit_i             instruction fields from the instruction register
//   branch_taken_i          branch compare result
//   mem_ready_i             memory completion strobe
//   pc_en_o, ir_en_o,
//   regWrite_en_o           PC / IR / register-file write enables
//   ALUctrl_o, ALUsrcA_o,
//   ALUsrcB_o, immSrc_o     ALU operation and operand / immediate selects
//   resultSrc_o, PCsrc_o    writeback source and next-PC select
//   mem_req_o, mem_we_o,
//   mem_size_o              memory request, write, access size (funct3)
//   instr_done_o            one-cycle retire pulse
//   trap_o, trap_cause_o    sticky trap flag and cause (01 illegal, 10 timeout)
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TIMEOUT_W   = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7bit_i,
    input  logic       branch_taken_i,
    input  logic       mem_ready_i,
    output logic       pc_en_o,
    output logic       ir_en_o,
    output logic       regWrite_en_o,
    output logic [3:0] ALUctrl_o,
    output logic       ALUsrcA_o,
    output logic       ALUsrcB_o,
    output logic [2:0] immSrc_o,
    output logic [1:0] resultSrc_o,
    output logic [1:0] PCsrc_o,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic [2:0] mem_size_o,
    output logic       instr_done_o,
    output logic       trap_o,
    output logic [1:0] trap_cause_o
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_CNT = TIMEOUT_W'(MEM_TIMEOUT);
    localparam logic                 TIMEOUT_EN  = (MEM_TIMEOUT != 0);

    state_t               state_q, state_d;
    logic [6:0]           op_q, op_d;
    logic [2:0]           f3_q, f3_d;
    logic                 b30_q, b30_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic [1:0]           cause_q, cause_d;

    // The IR is loaded on the FETCH ready edge, so during DECODE the fields are
    // only on the inputs; afterwards the latched copies are used.
    logic [6:0] op_f;
    logic [2:0] f3_f;
    logic       b30_f;

    logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
    logic       legal;
    logic [3:0] alu_sel;
    logic [2:0] imm_sel;
    logic       wait_hit;
    logic       decoded_state;

    always_comb begin
        op_f  = (state_q == S_DECODE) ? op_i        : op_q;
        f3_f  = (state_q == S_DECODE) ? funct3_i    : f3_q;
        b30_f = (state_q == S_DECODE) ? funct7bit_i : b30_q;
    end

    always_comb begin
        is_r      = (op_f == OP_R);
        is_i      = (op_f == OP_I);
        is_load   = (op_f == OP_LOAD);
        is_store  = (op_f == OP_STORE);
        is_branch = (op_f == OP_BRANCH);
        is_jal    = (op_f == OP_JAL);
        is_jalr   = (op_f == OP_JALR);
        is_lui    = (op_f == OP_LUI);
        is_auipc  = (op_f == OP_AUIPC);
        legal     = is_r | is_i | is_load | is_store | is_branch |
                    is_jal | is_jalr | is_lui | is_auipc;
    end

    always_comb begin
        alu_sel = ALU_ADD;
        if (is_r || is_i) begin
            case (f3_f)
                3'b000:  alu_sel = (is_r && b30_f) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_sel = ALU_SLL;
                3'b010:  alu_sel = ALU_SLT;
                3'b011:  alu_sel = ALU_SLTU;
                3'b100:  alu_sel = ALU_XOR;
                3'b101:  alu_sel = b30_f ? ALU_SRA : ALU_SRL;
                3'b110:  alu_sel = ALU_OR;
                default: alu_sel = ALU_AND;
            endcase
        end else if (is_branch) begin
            // beq/bne compare by subtraction; f3 01x is unused by RV32I branches
            case (f3_f[2:1])
                2'b10:   alu_sel = ALU_SLT;
                2'b11:   alu_sel = ALU_SLTU;
                default: alu_sel = ALU_SUB;
            endcase
        end
    end

    always_comb begin
        imm_sel = 3'b000;
        if (is_store)                 imm_sel = 3'b001;
        else if (is_branch)           imm_sel = 3'b010;
        else if (is_lui || is_auipc)  imm_sel = 3'b011;
        else if (is_jal)              imm_sel = 3'b100;
    end

    assign wait_hit      = TIMEOUT_EN && (wait_q == TIMEOUT_CNT);
    assign decoded_state = (state_q == S_DECODE) || (state_q == S_EXECUTE) ||
                           (state_q == S_MEMORY) || (state_q == S_WRITEBACK);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        f3_d          = f3_q;
        b30_d         = b30_q;
        cause_d       = cause_q;
        wait_d        = wait_q;
        pc_en_o       = 1'b0;
        ir_en_o       = 1'b0;
        regWrite_en_o = 1'b0;
        ALUctrl_o     = 4'b0000;
        ALUsrcA_o     = 1'b0;
        ALUsrcB_o     = 1'b0;
        immSrc_o      = 3'b000;
        resultSrc_o   = 2'b00;
        PCsrc_o       = 2'b00;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_size_o    = 3'b000;
        instr_done_o  = 1'b0;
        trap_o        = 1'b0;
        trap_cause_o  = cause_q;

        if (decoded_state) begin
            ALUctrl_o  = alu_sel;
            immSrc_o   = imm_sel;
            ALUsrcA_o  = is_auipc;
            ALUsrcB_o  = is_i | is_load | is_store | is_jalr | is_lui | is_auipc;
            mem_size_o = (is_load || is_store) ? f3_f : 3'b000;
        end

        case (state_q)
            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_en_o = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_hit) begin
                    cause_d = 2'b10;
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                op_d  = op_i;
                f3_d  = funct3_i;
                b30_d = funct7bit_i;
                if (legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    cause_d = 2'b01;
                    state_d = S_TRAP;
                end
            end
            S_EXECUTE: begin
                if (is_branch) begin
                    pc_en_o      = 1'b1;
                    instr_done_o = 1'b1;
                    PCsrc_o      = branch_taken_i ? 2'b01 : 2'b00;
                    state_d      = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                mem_req_o = 1'b1;
                mem_we_o  = is_store;
                if (mem_ready_i) begin
                    if (is_store) begin
                        pc_en_o      = 1'b1;
                        instr_done_o = 1'b1;
                        state_d      = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (wait_hit) begin
                    cause_d = 2'b10;
                    state_d = S_TRAP;
                end
            end
            S_WRITEBACK: begin
                regWrite_en_o = 1'b1;
                pc_en_o       = 1'b1;
                instr_done_o  = 1'b1;
                resultSrc_o   = is_load ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
                PCsrc_o       = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
                state_d       = S_FETCH;
            end
            S_TRAP: begin
                trap_o = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Counter restarts on every state change so it always times the current wait
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (((state_q == S_FETCH) || (state_q == S_MEMORY)) &&
                     !mem_ready_i && (wait_q != '1)) begin
            wait_d = wait_q + TIMEOUT_W'(1);
        end

        if (rst_i) begin
            pc_en_o       = 1'b0;
            ir_en_o       = 1'b0;
            regWrite_en_o = 1'b0;
            ALUctrl_o     = 4'b0000;
            ALUsrcA_o     = 1'b0;
            ALUsrcB_o     = 1'b0;
            immSrc_o      = 3'b000;
            resultSrc_o   = 2'b00;
            PCsrc_o       = 2'b00;
            mem_req_o     = 1'b0;
            mem_we_o      = 1'b0;
            mem_size_o    = 3'b000;
            instr_done_o  = 1'b0;
            trap_o        = 1'b0;
            trap_cause_o  = 2'b00;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            f3_q    <= '0;
            b30_q   <= 1'b0;
            wait_q  <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            b30_q   <= b30_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed vector bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [6:0] op_i = '0;
    logic [2:0] funct3_i = '0;
    logic       funct7bit_i = 1'b0;
    logic       branch_taken_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       pc_en_o, ir_en_o, regWrite_en_o, ALUsrcA_o, ALUsrcB_o;
    logic       mem_req_o, mem_we_o, instr_done_o, trap_o;
    logic [3:0] ALUctrl_o;
    logic [2:0] immSrc_o, mem_size_o;
    logic [1:0] resultSrc_o, PCsrc_o, trap_cause_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(4), .TIMEOUT_W(5)) dut (
        .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .funct3_i(funct3_i),
        .funct7bit_i(funct7bit_i), .branch_taken_i(branch_taken_i),
        .mem_ready_i(mem_ready_i), .pc_en_o(pc_en_o), .ir_en_o(ir_en_o),
        .regWrite_en_o(regWrite_en_o), .ALUctrl_o(ALUctrl_o), .ALUsrcA_o(ALUsrcA_o),
        .ALUsrcB_o(ALUsrcB_o), .immSrc_o(immSrc_o), .resultSrc_o(resultSrc_o),
        .PCsrc_o(PCsrc_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_size_o(mem_size_o), .instr_done_o(instr_done_o), .trap_o(trap_o),
        .trap_cause_o(trap_cause_o)
    );

    logic [24:0] all_o;
    assign all_o = {pc_en_o, ir_en_o, regWrite_en_o, ALUctrl_o, ALUsrcA_o, ALUsrcB_o,
                    immSrc_o, resultSrc_o, PCsrc_o, mem_req_o, mem_we_o, mem_size_o,
                    instr_done_o, trap_o, trap_cause_o};

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       b30;
        logic       taken;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       srcb;
        logic [1:0] res;
        logic [1:0] pcsrc;
        int         regw;
        int         retire;
        logic       mem;
        logic       we;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   retire_at;
        int   done_cnt;
        int   regw_cnt;
        v = vecs[idx];
        do_reset();
        op_i = v.op; funct3_i = v.f3; funct7bit_i = v.b30; branch_taken_i = v.taken;
        mem_ready_i = 1'b1;
        retire_at = -1; done_cnt = 0; regw_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk($sformatf("v%0d fetch ir_en", idx), ir_en_o, 1);
                chk($sformatf("v%0d fetch alu", idx), ALUctrl_o, 0);
            end
            if (c == 2) begin
                chk($sformatf("v%0d alu", idx), ALUctrl_o, v.alu);
                chk($sformatf("v%0d imm", idx), immSrc_o, v.imm);
                chk($sformatf("v%0d srcb", idx), ALUsrcB_o, v.srcb);
            end
            if (c == 3 && v.mem) begin
                chk($sformatf("v%0d mem_req", idx), mem_req_o, 1);
                chk($sformatf("v%0d mem_we", idx), mem_we_o, v.we);
                chk($sformatf("v%0d mem_size", idx), mem_size_o, v.f3);
            end
            if (regWrite_en_o) regw_cnt++;
            if (instr_done_o) begin
                done_cnt++;
                if (retire_at < 0) begin
                    retire_at = c;
                    chk($sformatf("v%0d pc_en", idx), pc_en_o, 1);
                    chk($sformatf("v%0d pcsrc", idx), PCsrc_o, v.pcsrc);
                    chk($sformatf("v%0d resultsrc", idx), resultSrc_o, v.res);
                end
            end
            if (retire_at >= 0 && c == retire_at + 1) begin
                chk($sformatf("v%0d back in fetch", idx), {mem_req_o, mem_we_o, instr_done_o}, 3'b100);
                break;
            end
            next_cycle();
            mem_ready_i = (c >= 1 && retire_at < 0);
        end
        chk($sformatf("v%0d retire cycle", idx), retire_at, v.retire);
        chk($sformatf("v%0d retire count", idx), done_cnt, 1);
        chk($sformatf("v%0d regwrite count", idx), regw_cnt, v.regw);
    endtask

    initial begin
        int req_cnt;
        int wb_at;
        int bad;

        vecs[0]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4'b0001, 3'b000, 1'b0, 2'b00, 2'b00, 1, 3, 1'b0, 1'b0};
        vecs[1]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0, 2'b00, 2'b00, 1, 3, 1'b0, 1'b0};
        vecs[2]  = '{7'b0110011, 3'b101, 1'b1, 1'b0, 4'b1001, 3'b000, 1'b0, 2'b00, 2'b00, 1, 3, 1'b0, 1'b0};
        vecs[3]  = '{7'b0110011, 3'b101, 1'b0, 1'b0, 4'b0111, 3'b000, 1'b0, 2'b00, 2'b00, 1, 3, 1'b0, 1'b0};
        vecs[4]  = '{7'b0110011, 3'b011, 1'b0, 1'b0, 4'b0110, 3'b000, 1'b0, 2'b00, 2'b00, 1, 3, 1'b0, 1'b0};
        vecs[5]  = '{7'b0110011, 3'b001, 1'b1, 1'b0, 4'b1000, 3'b000, 1'b0, 2'b00, 2'b00, 1, 3, 1'b0, 1'b0};
        vecs[6]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4'b0000, 3'b000, 1'b1, 2'b00, 2'b00, 1, 3, 1'b0, 1'b0};
        vecs[7]  = '{7'b0010011, 3'b101, 1'b1, 1'b0, 4'b1001, 3'b000, 1'b1, 2'b00, 2'b00, 1, 3, 1'b0, 1'b0};
        vecs[8]  = '{7'b0010011, 3'b110, 1'b0, 1'b0, 4'b0011, 3'b000, 1'b1, 2'b00, 2'b00, 1, 3, 1'b0, 1'b0};
        vecs[9]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b1, 2'b01, 2'b00, 1, 4, 1'b1, 1'b0};
        vecs[10] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4'b0000, 3'b001, 1'b1, 2'b00, 2'b00, 0, 3, 1'b1, 1'b1};
        vecs[11] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 4'b0001, 3'b010, 1'b0, 2'b00, 2'b01, 0, 2, 1'b0, 1'b0};
        vecs[12] = '{7'b1100011, 3'b001, 1'b0, 1'b0, 4'b0001, 3'b010, 1'b0, 2'b00, 2'b00, 0, 2, 1'b0, 1'b0};
        vecs[13] = '{7'b1100011, 3'b100, 1'b0, 1'b1, 4'b0101, 3'b010, 1'b0, 2'b00, 2'b01, 0, 2, 1'b0, 1'b0};
        vecs[14] = '{7'b1100011, 3'b111, 1'b0, 1'b1, 4'b0110, 3'b010, 1'b0, 2'b00, 2'b01, 0, 2, 1'b0, 1'b0};
        vecs[15] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4'b0000, 3'b100, 1'b0, 2'b10, 2'b01, 1, 3, 1'b0, 1'b0};
        vecs[16] = '{7'b1100111, 3'b000, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b1, 2'b10, 2'b10, 1, 3, 1'b0, 1'b0};
        vecs[17] = '{7'b0110111, 3'b000, 1'b0, 1'b0, 4'b0000, 3'b011, 1'b1, 2'b00, 2'b00, 1, 3, 1'b0, 1'b0};
        vecs[18] = '{7'b0010111, 3'b000, 1'b0, 1'b0, 4'b0000, 3'b011, 1'b1, 2'b00, 2'b00, 1, 3, 1'b0, 1'b0};

        // Outputs held at zero while reset is asserted, even with inputs active
        rst_i = 1'b1; mem_ready_i = 1'b1; op_i = 7'b0100011;
        next_cycle();
        @(negedge clk);
        chk("reset outputs zero", all_o, 0);
        next_cycle();
        rst_i = 1'b0; mem_ready_i = 1'b0;
        @(negedge clk);
        chk("post-reset fetch req", {mem_req_o, mem_we_o, trap_o, trap_cause_o}, 5'b10000);

        for (int i = 0; i < 19; i++) run_vec(i);

        // lw with memory ready delayed three cycles in MEMORY
        do_reset();
        op_i = 7'b0000011; funct3_i = 3'b010; funct7bit_i = 1'b0; mem_ready_i = 1'b1;
        next_cycle();
        mem_ready_i = 1'b0;
        next_cycle();
        next_cycle();
        req_cnt = 0; wb_at = -1;
        for (int k = 0; k < 10; k++) begin
            mem_ready_i = (k == 3);
            @(negedge clk);
            if (mem_req_o) req_cnt++;
            if (regWrite_en_o) begin
                wb_at = k;
                chk("lw delayed resultsrc", resultSrc_o, 2'b01);
                break;
            end
            next_cycle();
        end
        chk("lw delayed mem_req cycles", req_cnt, 4);
        chk("lw delayed writeback cycle", wb_at, 4);

        // Illegal opcode traps and stays trapped
        do_reset();
        op_i = 7'b1111111; funct3_i = 3'b000; mem_ready_i = 1'b1;
        next_cycle();
        mem_ready_i = 1'b0;
        @(negedge clk);
        chk("illegal no trap in decode", trap_o, 0);
        next_cycle();
        mem_ready_i = 1'b1;
        @(negedge clk);
        chk("illegal trap", {trap_o, trap_cause_o}, 3'b101);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            if ({mem_req_o, ir_en_o, pc_en_o, regWrite_en_o, instr_done_o} != 0 ||
                trap_o != 1'b1 || trap_cause_o != 2'b01) bad++;
        end
        chk("trap absorbing", bad, 0);
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        @(negedge clk);
        chk("trap cleared by reset", {trap_o, trap_cause_o, mem_req_o}, 4'b0001);

        // Fetch timeout with MEM_TIMEOUT=4
        do_reset();
        op_i = 7'b0110011; mem_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) next_cycle();
        @(negedge clk);
        chk("timeout not yet", {trap_o, mem_req_o}, 2'b01);
        next_cycle();
        @(negedge clk);
        chk("timeout trap", {trap_o, trap_cause_o, mem_req_o}, 4'b1100);

        // Ready on the timeout cycle wins
        do_reset();
        mem_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) next_cycle();
        mem_ready_i = 1'b1;
        @(negedge clk);
        chk("late ready ir_en", ir_en_o, 1);
        next_cycle();
        mem_ready_i = 1'b0;
        @(negedge clk);
        chk("late ready no trap", trap_o, 0);
        next_cycle();
        @(negedge clk);
        chk("late ready executes", trap_o, 0);

        // Reset during a store's MEMORY wait
        do_reset();
        op_i = 7'b0100011; funct3_i = 3'b010; mem_ready_i = 1'b1;
        next_cycle();
        mem_ready_i = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("store waiting we", {mem_req_o, mem_we_o}, 2'b11);
        next_cycle();
        rst_i = 1'b1;
        @(negedge clk);
        chk("reset mid-store", {mem_we_o, instr_done_o}, 2'b00);
        next_cycle();
        rst_i = 1'b0;
        @(negedge clk);
        chk("refetch after reset", {mem_req_o, mem_we_o, instr_done_o}, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
